// File: rtl/gcd_iter_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : gcd_iter_engine_if
// Purpose  : Operand/result handshake bundle for gcd_iter_engine.
//            Optional macro: GCD_ITER_STATS_EN (adds o_cycles).
// Revision : 1.0  initial release
// ============================================================================
interface gcd_iter_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [DATA_WIDTH-1:0] i_a;
  logic [DATA_WIDTH-1:0] i_b;
  logic [TAG_WIDTH-1:0]  i_in_tag;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [DATA_WIDTH-1:0] o_result;
  logic [TAG_WIDTH-1:0]  o_out_tag;
  logic                  o_busy;
`ifdef GCD_ITER_STATS_EN
  localparam int c_cycles_w = $clog2(2*DATA_WIDTH+1);
  logic [c_cycles_w-1:0] o_cycles;
`endif

  modport slave (
    input  i_in_valid, i_a, i_b, i_in_tag, i_out_ready,
    output o_in_ready, o_out_valid, o_result, o_out_tag, o_busy
`ifdef GCD_ITER_STATS_EN
    , output o_cycles
`endif
  );

  modport master (
    output i_in_valid, i_a, i_b, i_in_tag, i_out_ready,
    input  o_in_ready, o_out_valid, o_result, o_out_tag, o_busy
`ifdef GCD_ITER_STATS_EN
    , input o_cycles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/gcd_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : gcd_iter_engine
// Purpose  : Iterative binary (Stein) GCD, STEPS_PER_CYCLE steps per clock.
//            Optional macro: GCD_ITER_STATS_EN (RUN-cycle counter on o_cycles).
// Revision : 1.0  initial release
// ============================================================================
module gcd_iter_engine #(
  parameter int DATA_WIDTH      = 32,
  parameter int STEPS_PER_CYCLE = 2,
  parameter int TAG_WIDTH       = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  gcd_iter_engine_if.slave bus
);
  localparam int c_kw = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [c_kw-1:0]       k;
  } abk_t;

  state_t                r_state;
  state_t                w_state_nxt;
  abk_t                  r_abk;
  abk_t                  w_nxt;
  logic [DATA_WIDTH-1:0] r_result;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [TAG_WIDTH-1:0]  r_out_tag;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_terminal;
  logic                  w_accept;
  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_busy;

  // A zero operand freezes the tuple, so surplus steps in a cycle are no-ops.
  function automatic abk_t chain_steps(input abk_t s);
    abk_t v;
    v = s;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (v.a != '0 && v.b != '0) begin
        case ({v.a[0], v.b[0]})
          2'b00: begin
            v.a = v.a >> 1;
            v.b = v.b >> 1;
            v.k = v.k + c_kw'(1);
          end
          2'b01:   v.a = v.a >> 1;
          2'b10:   v.b = v.b >> 1;
          default: begin
            if (v.a >= v.b) v.a = (v.a - v.b) >> 1;
            else            v.b = (v.b - v.a) >> 1;
          end
        endcase
      end
    end
    return v;
  endfunction

  // Unsigned negate maps the most-negative value onto 2^(W-1) exactly.
  assign w_abs_a    = bus.i_a[DATA_WIDTH-1] ? -bus.i_a : bus.i_a;
  assign w_abs_b    = bus.i_b[DATA_WIDTH-1] ? -bus.i_b : bus.i_b;
  assign w_nxt      = chain_steps(r_abk);
  assign w_terminal = (w_nxt.a == '0) || (w_nxt.b == '0);
  assign w_res      = (w_nxt.a | w_nxt.b) << w_nxt.k;
  assign w_accept   = (r_state == S_IDLE) && bus.i_in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.i_in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_terminal) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abk     <= '0;
      r_tag     <= '0;
      r_result  <= '0;
      r_out_tag <= '0;
    end else if (w_accept) begin
      r_abk.a <= w_abs_a;
      r_abk.b <= w_abs_b;
      r_abk.k <= '0;
      r_tag   <= bus.i_in_tag;
    end else if (r_state == S_RUN) begin
      r_abk <= w_nxt;
      if (w_terminal) begin
        r_result  <= w_res;
        r_out_tag <= r_tag;
      end
    end
  end

`ifdef GCD_ITER_STATS_EN
  localparam int c_cw = $clog2(2*DATA_WIDTH+1);
  logic [c_cw-1:0] r_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_cycles <= '0;
    else if (w_accept)                       r_cycles <= '0;
    else if (r_state == S_RUN && !(&r_cycles)) r_cycles <= r_cycles + c_cw'(1);
  end

  assign bus.o_cycles = r_cycles;
`endif

  assign bus.o_in_ready  = w_in_ready;
  assign bus.o_out_valid = w_out_valid;
  assign bus.o_busy      = w_busy;
  assign bus.o_result    = r_result;
  assign bus.o_out_tag   = r_out_tag;
endmodule
`default_nettype wire

// File: tb/tb_gcd_iter_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gcd_iter_engine
// Purpose  : Directed scoreboard bench for gcd_iter_engine (S=2, S=1, S=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_gcd_iter_engine;
  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t q0[$];
  exp_t qw[$];

  always #5 clk = ~clk;

  gcd_iter_engine_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) bus0 ();
  gcd_iter_engine_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) bus1 ();
  gcd_iter_engine_if #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) bus2 ();

  gcd_iter_engine #(.DATA_WIDTH(W), .STEPS_PER_CYCLE(2), .TAG_WIDTH(TW)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  gcd_iter_engine #(.DATA_WIDTH(W), .STEPS_PER_CYCLE(1), .TAG_WIDTH(TW)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  gcd_iter_engine #(.DATA_WIDTH(W), .STEPS_PER_CYCLE(8), .TAG_WIDTH(TW)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  // Euclid on magnitudes: an independent reference to the DUT's Stein steps.
  function automatic logic [W-1:0] gold(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint x, y, t;
    x = a;
    y = b;
    if (x < 0) x = -x;
    if (y < 0) y = -y;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x[W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                       input logic [TW-1:0] tag);
    exp_t e;
    int   n;
    n = 0;
    while (bus0.o_in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_wait", bus0.o_in_ready, 1);
    bus0.i_a        = a;
    bus0.i_b        = b;
    bus0.i_in_tag   = tag;
    bus0.i_in_valid = 1'b1;
    e.res = gold(a, b);
    e.tag = tag;
    q0.push_back(e);
    tick();
    bus0.i_in_valid = 1'b0;
    check("busy_in_run", {bus0.o_busy, bus0.o_in_ready}, 2'b10);
  endtask

  task automatic wait_out0(output int r);
    r = 0;
    while (bus0.o_out_valid !== 1'b1 && r < 40) begin
      tick();
      r++;
    end
    check("out_valid_seen", bus0.o_out_valid, 1);
  endtask

  task automatic compare0(input string name, input int r);
    exp_t e;
    check({name, "_sb"}, 64'(q0.size() != 0), 1);
    if (q0.size() != 0) begin
      e = q0.pop_front();
      check({name, "_result"}, bus0.o_result, e.res);
      check({name, "_tag"}, bus0.o_out_tag, e.tag);
    end
    check({name, "_r_bound"}, 64'(r >= 1 && r <= 32), 1);
`ifdef GCD_ITER_STATS_EN
    check({name, "_cycles"}, bus0.o_cycles, r);
`endif
  endtask

  task automatic txn0(input string name, input logic signed [W-1:0] a,
                      input logic signed [W-1:0] b, input logic [TW-1:0] tag, output int r);
    send0(a, b, tag);
    wait_out0(r);
    compare0(name, r);
    tick();
    check({name, "_retired"}, {bus0.o_out_valid, bus0.o_in_ready, bus0.o_busy}, 3'b010);
  endtask

  task automatic txn_wide(input string name, input logic signed [W-1:0] a,
                          input logic signed [W-1:0] b);
    int   r1, r2, n;
    exp_t e;
    r1 = 0;
    r2 = 0;
    n  = 0;
    e.res = gold(a, b);
    e.tag = '0;
    qw.push_back(e);
    qw.push_back(e);
    bus1.i_a = a; bus1.i_b = b; bus1.i_in_tag = '0; bus1.i_in_valid = 1'b1;
    bus2.i_a = a; bus2.i_b = b; bus2.i_in_tag = '0; bus2.i_in_valid = 1'b1;
    tick();
    bus1.i_in_valid = 1'b0;
    bus2.i_in_valid = 1'b0;
    while ((r1 == 0 || r2 == 0) && n < 100) begin
      tick();
      n++;
      if (r1 == 0 && bus1.o_out_valid === 1'b1) begin
        r1 = n;
        e  = qw.pop_front();
        check({name, "_s1_result"}, bus1.o_result, e.res);
`ifdef GCD_ITER_STATS_EN
        check({name, "_s1_cycles"}, bus1.o_cycles, r1);
`endif
      end
      if (r2 == 0 && bus2.o_out_valid === 1'b1) begin
        r2 = n;
        e  = qw.pop_front();
        check({name, "_s8_result"}, bus2.o_result, e.res);
`ifdef GCD_ITER_STATS_EN
        check({name, "_s8_cycles"}, bus2.o_cycles, r2);
`endif
      end
    end
    check({name, "_s1_done"}, 64'(r1 != 0), 1);
    check({name, "_s8_done"}, 64'(r2 != 0), 1);
    check({name, "_s1_r_bound"}, 64'(r1 <= 2*W), 1);
    check({name, "_s8_r_bound"}, 64'(r2 <= (2*W + 7) / 8), 1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus0.i_in_valid = 1'b0; bus0.i_out_ready = 1'b1; bus0.i_a = '0; bus0.i_b = '0; bus0.i_in_tag = '0;
    bus1.i_in_valid = 1'b0; bus1.i_out_ready = 1'b1; bus1.i_a = '0; bus1.i_b = '0; bus1.i_in_tag = '0;
    bus2.i_in_valid = 1'b0; bus2.i_out_ready = 1'b1; bus2.i_a = '0; bus2.i_b = '0; bus2.i_in_tag = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_flags", {bus0.o_in_ready, bus0.o_out_valid, bus0.o_busy}, 3'b100);
    check("rst_result", bus0.o_result, 0);
    check("rst_tag", bus0.o_out_tag, 0);
`ifdef GCD_ITER_STATS_EN
    check("rst_cycles", bus0.o_cycles, 0);
`endif
    rst = 1'b0;
    tick();

    txn0("g48_18", 48, 18, 4'h3, r);
    txn0("gm12_8", -12, 8, 4'h1, r);
    txn0("g0_m7", 0, -7, 4'h2, r);
    check("g0_m7_r1", r, 1);
    txn0("g0_0", 0, 0, 4'hF, r);
    check("g0_0_r1", r, 1);
    txn0("gmin_0", 32'sh80000000, 0, 4'h4, r);
    check("gmin_0_r1", r, 1);
    txn0("gmin_min", 32'sh80000000, 32'sh80000000, 4'h5, r);
    txn0("gmax_1", 32'sh7FFFFFFF, 1, 4'h6, r);

    txn_wide("wmax", 32'sh7FFFFFFF, 32'sh7FFFFFFE);
    txn_wide("w1071", 1071, 462);

    // Backpressure: result held while the consumer stalls, new offers ignored.
    bus0.i_out_ready = 1'b0;
    send0(1071, 462, 4'h8);
    wait_out0(r);
    compare0("bp", r);
    for (int i = 0; i < 10; i++) begin
      bus0.i_a        = 99;
      bus0.i_b        = 33;
      bus0.i_in_tag   = 4'h7;
      bus0.i_in_valid = (i % 2 == 0);
      tick();
      check("bp_hold", {bus0.o_out_valid, bus0.o_in_ready, bus0.o_out_tag, bus0.o_result},
            {1'b1, 1'b0, 4'h8, 32'd21});
    end
    // Retire and offer together: the offer is only taken once back in IDLE.
    begin
      exp_t e;
      e.res = gold(99, 33);
      e.tag = 4'h7;
      q0.push_back(e);
    end
    bus0.i_in_valid  = 1'b1;
    bus0.i_out_ready = 1'b1;
    tick();
    check("bp_retire", {bus0.o_out_valid, bus0.o_in_ready, bus0.o_busy}, 3'b010);
    tick();
    bus0.i_in_valid = 1'b0;
    check("bp_next_accept", {bus0.o_in_ready, bus0.o_busy}, 2'b01);
    wait_out0(r);
    compare0("bp_next", r);
    tick();

    // Reset mid-RUN drops the transaction.
    send0(1071, 462, 4'h9);
    #2;
    rst = 1'b1;
    #1;
    check("rst_run_flags", {bus0.o_out_valid, bus0.o_in_ready, bus0.o_busy}, 3'b010);
    void'(q0.pop_front());
    #1;
    rst = 1'b0;
    tick();

    // Reset mid-DONE drops Out_valid asynchronously.
    bus0.i_out_ready = 1'b0;
    send0(1071, 462, 4'hA);
    wait_out0(r);
    compare0("pre_rst_done", r);
    #2;
    rst = 1'b1;
    #1;
    check("rst_done_flags", {bus0.o_out_valid, bus0.o_in_ready, bus0.o_busy}, 3'b010);
    check("rst_done_result", bus0.o_result, 0);
    #1;
    rst = 1'b0;
    bus0.i_out_ready = 1'b1;
    tick();
    txn0("post_rst", 1071, 462, 4'hB, r);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gcd_iter_engine.md
Name: gcd_iter_engine

Overview:
Parametrised iterative binary (Stein) GCD engine. It succeeds the fixed-depth gcd pipeline with these additions:
- valid/ready handshakes on both input and output, with backpressure;
- a configurable number of algorithm steps per clock (STEPS_PER_CYCLE);
- a passthrough transaction tag;
- exact handling of zero and most-negative operands.

It sits between the operand source and result consumer wherever a low-area, throughput-tolerant GCD is needed. One transaction is in flight at a time.

Parameters:
DATA_WIDTH, 32, operand width W (signed two's-complement inputs), W >= 4
STEPS_PER_CYCLE, 2, binary-GCD steps evaluated combinationally per RUN cycle, 1..8
TAG_WIDTH, 4, width of the user tag carried from input to output, >= 1

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
In_valid  input  1  operand pair valid
In_ready  output  1  engine can accept operands (high only in IDLE)
A  input  DATA_WIDTH  signed operand A
B  input  DATA_WIDTH  signed operand B
In_tag  input  TAG_WIDTH  user tag, captured with operands
Out_valid  output  1  Result/Out_tag valid
Out_ready  input  1  consumer accepts result
Result  output  DATA_WIDTH  unsigned gcd(|A|,|B|)
Out_tag  output  TAG_WIDTH  tag of the transaction
Busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE; In_ready=1; Out_valid=0; Busy=0; Result=0; Out_tag=0; internal a, b, k and tag registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - In_ready=1.
  - On In_valid: latch a=|A|, b=|B| (W-bit unsigned; |-2^(W-1)| = 2^(W-1) exactly, no overflow), k=0, tag=In_tag.
  - Next state RUN.
- One step on (a,b,k):
  - a==0 or b==0: no-op (terminal).
  - both even: a>>=1, b>>=1, k+=1.
  - a even only: a>>=1.
  - b even only: b>>=1.
  - both odd, a>=b: a=(a-b)>>1.
  - both odd, a<b: b=(b-a)>>1.
- RUN:
  - Each cycle chains STEPS_PER_CYCLE steps combinationally, then registers a, b, k.
  - If the chained result is terminal: Result <= (a|b)<<k, Out_tag <= tag, Out_valid <= 1, next state DONE.
  - Steps after the terminal point within a cycle are no-ops.
- k width is clog2(W)+1. Shift-out cannot lose bits, because a gcd fits in W bits.
- DONE:
  - Out_valid=1; Result and Out_tag held stable.
  - On Out_ready: Out_valid <= 0, next state IDLE. In_ready rises the same edge.
  - Out_ready low holds DONE indefinitely.
- Latency:
  - Operands are accepted at edge N; RUN occupies edges N+1 onward.
  - Out_valid is high after edge N+R, where R = number of RUN cycles, 1 <= R <= ceil(2W/STEPS_PER_CYCLE).
  - Each non-terminal step reduces bitlen(a)+bitlen(b) by at least 1.
- Zero cases:
  - gcd(0,x) = |x|.
  - gcd(0,0) = 0.
  - A zero operand gives R = 1.
- Throughput: no overlap. In_valid in RUN/DONE is ignored (In_ready=0); the source holds its data.
- Reset mid-RUN or mid-DONE aborts the transaction immediately. Out_valid drops asynchronously and no partial result is emitted.
- Out_valid/Result change only on Clk edges or Reset.
- Simultaneous Out_ready and In_valid in DONE: only the result is retired. In_valid is taken on the next cycle, in IDLE.

Optional Feature:
GCD_ITER_STATS_EN
- Defined:
  - Adds output port Out_cycles [clog2(2*DATA_WIDTH+1)-1:0] = number of RUN cycles R used by the transaction.
  - Valid with Out_valid and held in DONE.
  - Reset value 0.
  - Counter clears on input accept and saturates at all-ones.
- Undefined: the port and counter are absent. Remaining behaviour is identical.

Test Plan:
1. W=32, S=2: A=48, B=18, Out_ready=1 -> Result=6, Out_tag echoed, Out_valid one cycle, In_ready back high the next cycle.
2. A=-12, B=8 -> Result=4. A=0, B=-7 -> 7. A=0, B=0 -> 0, with R=1 (Out_valid after 2nd edge from accept).
3. A=-2^31, B=0 -> Result=0x80000000. A=-2^31, B=-2^31 -> 0x80000000. A=2^31-1, B=1 -> 1.
4. A=0x7FFFFFFF, B=0x7FFFFFFE with S=1, then S=8 -> Result=1 in both. R <= 64 (S=1) and <= 8 (S=8). With GCD_ITER_STATS_EN, Out_cycles equals the measured R.
5. Backpressure: Out_ready low 10 cycles after Out_valid -> Result/Out_tag stable, In_ready=0, new In_valid pulses ignored. Out_ready high -> retire, then the next operand pair is accepted.
6. Reset asserted mid-RUN (A=1071, B=462) -> Out_valid=0, In_ready=1, Busy=0 immediately. The next transaction A=1071, B=462 -> Result=21.
